bconv_binpool: RTL and testbench

//  Stage directly downstream of the binary convolution. Consumes its 4-bit XNOR-popcount

---
 rtl/bnn_pkg.sv | 15 +
 rtl/bconv_binpool_if.sv | 18 +
 rtl/bnn_pool_linebuf.sv | 31 +++
 rtl/bconv_binpool.sv | 109 ++++++++++
 tb/tb_bconv_binpool.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/bnn_pkg.sv
// ---------------------------------------------------------------
// bnn_pkg : shared types and constants for the binary-NN stages
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package bnn_pkg;
  localparam int POP_W          = 4;
  localparam int THRESH_DEFAULT = 5;

  typedef enum logic {RUN = 1'b0, DONE = 1'b1} binpool_state_t;
  typedef logic [POP_W-1:0] pop_t;
endpackage

`default_nettype wire

// File: rtl/bconv_binpool_if.sv
// ---------------------------------------------------------------
// bconv_binpool_if : valid/ready popcount stream into the pooling stage
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface bconv_binpool_if;
  import bnn_pkg::*;

  logic in_valid;
  logic in_ready;
  pop_t in_pop;

  modport master (output in_valid, output in_pop, input in_ready);
  modport slave  (input in_valid, input in_pop, output in_ready);
endinterface

`default_nettype wire

// File: rtl/bnn_pool_linebuf.sv
// ---------------------------------------------------------------
// bnn_pool_linebuf : one-bit-per-entry line buffer, combinational read
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module bnn_pool_linebuf #(
  parameter  int DEPTH = 13,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic          wdata,
  output logic          rdata
);
  logic [DEPTH-1:0] mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];
endmodule

`default_nettype wire

// File: rtl/bconv_binpool.sv
// ---------------------------------------------------------------
// bconv_binpool : threshold conv popcounts and 2x2 OR-pool into a frame
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module bconv_binpool
  import bnn_pkg::*;
#(
  parameter  int IN_H   = 26,
  parameter  int IN_W   = 26,
  parameter  int THRESH = THRESH_DEFAULT,
  localparam int OUT_H  = IN_H / 2,
  localparam int OUT_W  = IN_W / 2
) (
  input  logic                   clk,
  input  logic                   rst,
  bconv_binpool_if.slave         in_if,
  output logic [OUT_H*OUT_W-1:0] frame_o,
  output logic                   frame_valid,
  output logic                   done
);
  localparam int RW = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int LW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int FW = (OUT_H * OUT_W > 1) ? $clog2(OUT_H * OUT_W) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(IN_H - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(IN_W - 1);

  binpool_state_t state;
  logic [RW-1:0]  row;
  logic [CW-1:0]  col;
  logic           pair;

  logic           accept;
  logic           bit_in;
  logic           pooled;
  logic           last_px;
  logic           lb_we;
  logic           lb_rd;
  logic [LW-1:0]  lb_idx;
  logic [FW-1:0]  frame_idx;

  assign in_if.in_ready = (state == RUN) && !rst;
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign bit_in         = (32'(in_if.in_pop) >= 32'(THRESH));
  assign pooled         = pair | bit_in;
  assign last_px        = (row == LAST_ROW) && (col == LAST_COL);
  assign lb_idx         = LW'(col >> 1);
  assign frame_idx      = FW'(row >> 1) * FW'(OUT_W) + FW'(col >> 1);

  // Even rows park the horizontal pair result; odd rows merge it into the frame.
  assign lb_we = accept && col[0] && !row[0];

  bnn_pool_linebuf #(.DEPTH(OUT_W)) u_linebuf (
    .clk   (clk),
    .rst   (rst),
    .we    (lb_we),
    .idx   (lb_idx),
    .wdata (pooled),
    .rdata (lb_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      row         <= '0;
      col         <= '0;
      pair        <= 1'b0;
      frame_o     <= '0;
      frame_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          if (accept) begin
            if (accept && col[0] && row[0]) begin
              frame_o[frame_idx] <= lb_rd | pooled;
            end
            if (last_px) begin
              state       <= DONE;
              done        <= 1'b1;
              frame_valid <= 1'b1;
              row         <= '0;
              col         <= '0;
              pair        <= 1'b0;
            end else begin
              frame_valid <= 1'b0;
              if (!col[0]) begin
                pair <= bit_in;
              end
              if (col == LAST_COL) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end
        DONE:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_bconv_binpool.sv
// ---------------------------------------------------------------
// tb_bconv_binpool : directed + random checks of 26x26 and 5x5 builds
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_bconv_binpool;
  import bnn_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bconv_binpool_if ifa();
  bconv_binpool_if ifb();

  logic [168:0] fa;
  logic         fva, da;
  logic [3:0]   fb;
  logic         fvb, db;

  bconv_binpool #(.IN_H(26), .IN_W(26), .THRESH(5)) dut_a (
    .clk(clk), .rst(rst), .in_if(ifa), .frame_o(fa), .frame_valid(fva), .done(da)
  );
  bconv_binpool #(.IN_H(5), .IN_W(5), .THRESH(5)) dut_b (
    .clk(clk), .rst(rst), .in_if(ifb), .frame_o(fb), .frame_valid(fvb), .done(db)
  );

  int cyc = 0;
  int dca = 0;
  int dcb = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (da) dca <= dca + 1;
    if (db) dcb <= dcb + 1;
  end

  int checks = 0;
  int errors = 0;
  int pa [26][26];
  int pb [5][5];

  task automatic chk(input string tag, input logic [168:0] obs, input logic [168:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pix(input bit sel, input int r, input int c);
    return sel ? pb[r][c] : pa[r][c];
  endfunction

  // Reference: binarise each pixel, then OR every complete 2x2 window.
  function automatic logic [168:0] ref_frame(input bit sel);
    logic [168:0] res;
    int h, w;
    h = sel ? 5 : 26;
    w = h;
    res = '0;
    for (int r = 0; r < h / 2; r++)
      for (int c = 0; c < w / 2; c++)
        if (pix(sel, 2*r, 2*c) >= 5 || pix(sel, 2*r, 2*c+1) >= 5 ||
            pix(sel, 2*r+1, 2*c) >= 5 || pix(sel, 2*r+1, 2*c+1) >= 5)
          res[r*(w/2)+c] = 1'b1;
    return res;
  endfunction

  task automatic set_in(input bit sel, input logic v, input int p);
    if (sel) begin ifb.in_valid = v; ifb.in_pop = pop_t'(p); end
    else     begin ifa.in_valid = v; ifa.in_pop = pop_t'(p); end
  endtask

  task automatic beat(input bit sel, input int p);
    bit acc;
    int g;
    acc = 1'b0;
    g = 0;
    set_in(sel, 1'b1, p);
    while (!acc && g < 50) begin
      @(negedge clk);
      acc = sel ? ifb.in_ready : ifa.in_ready;
      @(posedge clk); #1;
      g++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout observed=0 expected=1");
    end
  endtask

  task automatic run(input bit sel, input int first, input int last, input int pct,
                     output int nb);
    int w;
    w = sel ? 5 : 26;
    nb = 0;
    for (int k = first; k < last; k++) begin
      if (pct > 0 && $urandom_range(99) < pct) begin
        set_in(sel, 1'b0, 0);
        @(posedge clk); #1;
        nb++;
      end
      beat(sel, pix(sel, k / w, k % w));
    end
  endtask

  task automatic finish_done(input bit sel);
    @(posedge clk); #1;
    set_in(sel, 1'b0, 0);
  endtask

  task automatic fill_a(input int v);
    for (int r = 0; r < 26; r++)
      for (int c = 0; c < 26; c++)
        pa[r][c] = v;
  endtask

  initial begin
    int nb, e0, d0;
    logic [168:0] ones;
    ones = '1;
    rst = 1'b1;
    set_in(1'b0, 1'b0, 0);
    set_in(1'b1, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("ready_in_rst", 169'(ifa.in_ready), 169'(0));
    chk("reset_frame", fa, '0);
    rst = 1'b0;
    #1;
    chk("reset_state", {166'(0), ifa.in_ready, fva, da}, {166'(0), 3'b100});

    // All-9 gapless frame
    fill_a(9);
    d0 = dca;
    run(1'b0, 0, 676, 0, nb);
    chk("all9_frame", fa, ref_frame(1'b0));
    chk("all9_ones", fa, ones);
    chk("all9_flags", {166'(0), ifa.in_ready, fva, da}, {166'(0), 3'b011});
    @(posedge clk); #1;
    chk("all9_after", {167'(0), ifa.in_ready, da}, {167'(0), 2'b10});
    chk("all9_done_cnt", 169'(dca - d0), 169'(1));
    set_in(1'b0, 1'b0, 0);

    // All-4 frame
    fill_a(4);
    run(1'b0, 0, 676, 0, nb);
    chk("all4_frame", fa, '0);
    chk("all4_fv", 169'(fva), 169'(1));
    finish_done(1'b0);

    // Single pixel at threshold, then just below it
    fill_a(0);
    pa[3][4] = 5;
    run(1'b0, 0, 676, 0, nb);
    chk("single5_ref", fa, ref_frame(1'b0));
    chk("single5_bit15", fa, 169'(1) << 15);
    finish_done(1'b0);
    pa[3][4] = 4;
    run(1'b0, 0, 676, 0, nb);
    chk("single4", fa, '0);
    finish_done(1'b0);

    // Random stream with bubbles
    for (int r = 0; r < 26; r++)
      for (int c = 0; c < 26; c++)
        pa[r][c] = $urandom_range(9);
    e0 = cyc;
    run(1'b0, 0, 676, 30, nb);
    chk("random_frame", fa, ref_frame(1'b0));
    @(posedge clk); #1;
    chk("random_ready", 169'(ifa.in_ready), 169'(1));
    chk("random_cycles", 169'(cyc - e0), 169'(676 + nb + 1));
    set_in(1'b0, 1'b0, 0);

    // Reset mid-frame, then a full all-9 frame
    fill_a(9);
    d0 = dca;
    run(1'b0, 0, 300, 0, nb);
    set_in(1'b0, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_mid_rst", 169'(ifa.in_ready), 169'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_frame", fa, '0);
    chk("abort_fv", 169'(fva), 169'(0));
    run(1'b0, 0, 40, 0, nb);
    chk("post_rst_fv", 169'(fva), 169'(0));
    run(1'b0, 40, 676, 0, nb);
    chk("post_rst_frame", fa, ones);
    finish_done(1'b0);
    chk("abort_no_done", 169'(dca - d0), 169'(1));

    // 5x5 build: odd dimensions drop last row/col
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        pb[r][c] = 9;
    d0 = dcb;
    run(1'b1, 0, 25, 0, nb);
    chk("b_all9", 169'(fb), ref_frame(1'b1));
    chk("b_all9_const", 169'(fb), 169'(4'hF));
    chk("b_fv_set", 169'(fvb), 169'(1));
    finish_done(1'b1);
    chk("b_done_cnt", 169'(dcb - d0), 169'(1));
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        pb[r][c] = (r == 4 || c == 4) ? 9 : 0;
    run(1'b1, 0, 1, 0, nb);
    chk("b_fv_clear", 169'(fvb), 169'(0));
    run(1'b1, 1, 25, 0, nb);
    chk("b_edge_ignored", 169'(fb), ref_frame(1'b1));
    chk("b_edge_zero", 169'(fb), '0);
    finish_done(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
